// File: rtl/bitwise_pkg.sv
// Shared definitions for the bitwise arbiter slice.
//   OP_*      : 2-bit opcode encodings understood by bitwise_ops
//   state_t   : response-register FSM encoding (IDLE = empty, FULL = held)
//   OPS_W     : native operand width of bitwise_ops
package bitwise_pkg;

    localparam int OPS_W = 16;

    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_INV  = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

endpackage

// File: rtl/bitwise_ops.sv
// Combinational 16-bit bitwise unit.
// Ports:
//   a, b : operands
//   op   : OP_AND / OP_OR / OP_INV (~a) / OP_RSVD
//   y    : result; 0 for the reserved opcode
module bitwise_ops
    import bitwise_pkg::*;
#(
    parameter int DATA_W = OPS_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_INV:  y = ~a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Ports:
//   valid[1:0] : request lines
//   last       : requester granted most recently
//   grant[1:0] : one-hot grant (all zero when nothing is valid)
//   any        : at least one request is valid
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant,
    output logic       any
);

    always_comb begin
        grant = 2'b00;
        any   = |valid;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // On a tie the requester that did not win last time goes first.
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/bitwise_arbiter.sv
// Shares one bitwise_ops unit between two valid/ready requesters with
// round-robin grants, returning results through a single registered
// response port tagged with the requester id.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A requester holds a/b/op stable while valid=1 and ready=0. The
// response port holds data/id/err stable while rsp_valid=1 and rsp_ready=0.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   req0_valid/ready/a/b/op      requester 0 command channel
//   req1_valid/ready/a/b/op      requester 1 command channel
//   rsp_valid/ready/data/id/err  response channel (err = reserved opcode)
//   done_cnt0, done_cnt1         wrapping count of responses delivered per id
//   fsm_state                    current FSM state (0 = IDLE, 1 = FULL)
module bitwise_arbiter
    import bitwise_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [1:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [1:0]        req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  done_cnt0,
    output logic [CNT_W-1:0]  done_cnt1,
    output logic              fsm_state
);

    state_t            state_q;
    state_t            state_d;
    logic              last_grant;
    logic [1:0]        grant;
    logic              any_valid;
    logic              can_accept;
    logic              accept;
    logic              sel;
    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;
    logic [1:0]        op_sel;
    logic [DATA_W-1:0] ops_y;

    rr_arb2 u_arb (
        .valid ({req1_valid, req0_valid}),
        .last  (last_grant),
        .grant (grant),
        .any   (any_valid)
    );

    // A held response can be replaced in the same cycle it drains.
    assign can_accept = (state_q == ST_IDLE) || rsp_ready;
    assign accept     = can_accept && any_valid;
    assign req0_ready = can_accept && grant[0];
    assign req1_ready = can_accept && grant[1];

    assign sel    = grant[1];
    assign a_sel  = sel ? req1_a  : req0_a;
    assign b_sel  = sel ? req1_b  : req0_b;
    assign op_sel = sel ? req1_op : req0_op;

    bitwise_ops #(.DATA_W(DATA_W)) u_ops (
        .a  (a_sel),
        .b  (b_sel),
        .op (op_sel),
        .y  (ops_y)
    );

    assign rsp_valid = (state_q == ST_FULL);
    assign fsm_state = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_FULL;
            ST_FULL: if (rsp_ready && !accept) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            rsp_data   <= (op_sel == OP_RSVD) ? '0 : ops_y;
            rsp_err    <= (op_sel == OP_RSVD);
            rsp_id     <= sel;
            last_grant <= sel;
        end
    end

    // Counts the response leaving the port, independent of any new accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_cnt0 <= '0;
            done_cnt1 <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (rsp_id) begin
                done_cnt1 <= done_cnt1 + 1'b1;
            end else begin
                done_cnt0 <= done_cnt0 + 1'b1;
            end
        end
    end

endmodule
